// File: rtl/regfile_access_ctrl_if.sv
// Debug access port of the register-file controller: req/ack handshake
// with a single register number, write data and read-back data.
interface regfile_access_ctrl_if;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_sel_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;

   modport master (
      output dbg_req_i, dbg_we_i, dbg_sel_i, dbg_wdata_i,
      input  dbg_ack_o, dbg_rdata_o
   );

   modport slave (
      input  dbg_req_i, dbg_we_i, dbg_sel_i, dbg_wdata_i,
      output dbg_ack_o, dbg_rdata_o
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Shares a 32x32 register file between core writeback/reads, a debug port
// and a zeroing sequence that clears x1..x31.
module regfile_access_ctrl #(
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter int unsigned MAX_WAIT       = 8
) (
   input  logic                    clk,
   input  logic                    rst_ni,
   input  logic                    core_wr_en_i,
   input  logic [4:0]              core_wr_sel_i,
   input  logic [31:0]             core_wr_data_i,
   input  logic [4:0]              core_rd1_sel_i,
   input  logic [4:0]              core_rd2_sel_i,
   output logic                    core_stall_o,
   regfile_access_ctrl_if.slave    dbg,
   input  logic                    clr_req_i,
   output logic                    busy_o,
   output logic [31:0]             rf_in_o,
   output logic [4:0]              rf_in_sel_o,
   output logic                    rf_in_en_o,
   output logic [4:0]              rf_out1_sel_o,
   output logic [4:0]              rf_out2_sel_o,
   input  logic [31:0]             rf_out1_i
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD_WAIT, S_ACK} state_t;
   localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

   state_t      r_state, w_nxt_state;
   logic [4:0]  r_idx, w_nxt_idx;
   logic [7:0]  r_wait, w_nxt_wait;
   logic [31:0] r_rdata;
   logic        r_rd_zero;

   logic        w_rd_grant;
   logic        w_stall;
   logic        w_en;
   logic [4:0]  w_sel;
   logic [31:0] w_din;
   logic [4:0]  w_rd1_sel;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_wait  = r_wait;
      w_rd_grant  = 1'b0;
      w_stall     = 1'b0;
      w_en        = core_wr_en_i;
      w_sel       = core_wr_sel_i;
      w_din       = core_wr_data_i;
      w_rd1_sel   = core_rd1_sel_i;
      case (r_state)
         S_CLEAR: begin
            w_en    = 1'b1;
            w_sel   = r_idx;
            w_din   = 32'd0;
            w_stall = 1'b1;
            if (r_idx == 5'd31) begin
               w_nxt_state = S_IDLE;
               w_nxt_idx   = 5'd1;
            end else begin
               w_nxt_idx = r_idx + 5'd1;
            end
         end
         S_IDLE: begin
            if (dbg.dbg_req_i && !dbg.dbg_we_i) begin
               w_rd1_sel   = dbg.dbg_sel_i;
               w_stall     = 1'b1;
               w_en        = 1'b0;
               w_rd_grant  = 1'b1;
               w_nxt_state = S_RD_WAIT;
            end else if (dbg.dbg_req_i) begin
               // Core writeback keeps priority until the debug write has waited MAX_WAIT times
               if (!core_wr_en_i || (r_wait >= 8'(MAX_WAIT))) begin
                  w_en        = (dbg.dbg_sel_i != 5'd0);
                  w_sel       = dbg.dbg_sel_i;
                  w_din       = dbg.dbg_wdata_i;
                  w_stall     = core_wr_en_i;
                  w_nxt_state = S_ACK;
               end else begin
                  w_nxt_wait = r_wait + 8'd1;
               end
            end else if (clr_req_i) begin
               w_nxt_state = S_CLEAR;
               w_nxt_idx   = 5'd1;
            end
         end
         S_RD_WAIT: w_nxt_state = S_ACK;
         S_ACK: begin
            w_nxt_wait  = 8'd0;
            w_nxt_state = S_IDLE;
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_idx     <= 5'd1;
         r_wait    <= 8'd0;
         r_rdata   <= 32'd0;
         r_rd_zero <= 1'b0;
      end else begin
         r_idx  <= w_nxt_idx;
         r_wait <= w_nxt_wait;
         if (w_rd_grant) begin
            r_rd_zero <= (dbg.dbg_sel_i == 5'd0);
         end
         if (r_state == S_RD_WAIT) begin
            r_rdata <= r_rd_zero ? 32'd0 : rf_out1_i;
         end
      end
   end

   // Write enable is held off while reset is asserted even when the reset state is CLEAR
   assign rf_in_en_o      = w_en & rst_ni;
   assign rf_in_sel_o     = w_sel;
   assign rf_in_o         = w_din;
   assign rf_out1_sel_o   = w_rd1_sel;
   assign rf_out2_sel_o   = core_rd2_sel_i;
   assign core_stall_o    = w_stall;
   assign busy_o          = (r_state == S_CLEAR);
   assign dbg.dbg_ack_o   = (r_state == S_ACK);
   assign dbg.dbg_rdata_o = r_rdata;

endmodule
